// File: rtl/mux_2_1.sv
// 2:1 mux with a zero-latency combinational output, a registered copy, and an
// optional saturating select-transition counter enabled by MUX_2_1_SEL_CNT_EN.
module mux_2_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_cnt
);

  // Conditional operator merges a/b bitwise when s is X/Z in 4-state sim.
  assign out = s ? b : a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out;
  end

`ifdef MUX_2_1_SEL_CNT_EN
  logic s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d     <= 1'b0;
      sel_cnt <= '0;
    end else begin
      s_d <= s;
      if ((s != s_d) && (sel_cnt != '1)) sel_cnt <= sel_cnt + CNT_W'(1);
    end
  end
`else
  assign sel_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// Randomized self-checking bench for mux_2_1 (WIDTH=8, CNT_W=2) against a
// behavioural reference; counter expectations follow MUX_2_1_SEL_CNT_EN.
module tb_mux_2_1;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef MUX_2_1_SEL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic [WIDTH-1:0] a, b, out, out_q;
  logic             s, clk, rst;
  logic [CNT_W-1:0] sel_cnt;
  int checks, failures;

  mux_2_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .a(a), .b(b), .s(s), .out(out),
    .clk(clk), .rst(rst), .out_q(out_q), .sel_cnt(sel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: select by indexing a two-entry source table.
  function automatic logic [WIDTH-1:0] ref_out(logic [WIDTH-1:0] fa, logic [WIDTH-1:0] fb, logic fs);
    logic [WIDTH-1:0] src [2];
    src[0] = fa;
    src[1] = fb;
    return src[int'(fs)];
  endfunction

  logic [WIDTH-1:0] m_q;
  int               m_cnt;
  int               m_prev_s;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= '0;
      m_cnt    <= 0;
      m_prev_s <= 0;
    end else begin
      m_q      <= ref_out(a, b, s);
      m_prev_s <= int'(s);
      if (int'(s) != m_prev_s) m_cnt <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
  end

  function automatic int exp_cnt();
    return CNT_EN ? m_cnt : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exh_tbl;
    logic [2:0] v;
    int cnt_seq [6];
    exh_tbl = 8'b10101100;
    cnt_seq = '{1, 2, 3, 3, 3, 3};
    checks = 0; failures = 0;
    rst = 1'b0; a = '0; b = '0; s = 1'b0;

    // Reset takes effect between edges
    #2 rst = 1'b1;
    #1 chk("rst_out_q", 32'(out_q), 0);
    chk("rst_sel_cnt", 32'(sel_cnt), 0);
    a = 8'h3C;
    #1 chk("rst_out_follows", 32'(out), 32'h3C);
    @(posedge clk); #1;
    chk("rst_held_out_q", 32'(out_q), 0);
    rst = 1'b0;

    // Exhaustive {s,a,b}, each held 50 ns
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      s = v[2]; a = {WIDTH{v[1]}}; b = {WIDTH{v[0]}};
      #1 chk("exh_out", 32'(out), exh_tbl[i] ? 32'hFF : 32'h00);
      chk("exh_out_q", 32'(out_q), 32'(m_q));
      #49;
    end

    // Registered latency
    s = 1'b0; a = 8'h3C; b = 8'hA5;
    @(posedge clk); #1;
    s = 1'b1;
    #1 chk("lat_out", 32'(out), 32'hA5);
    chk("lat_out_q_old", 32'(out_q), 32'h3C);
    @(posedge clk); #1;
    chk("lat_out_q_new", 32'(out_q), 32'hA5);

    // Build up sel_cnt, then async reset between edges
    for (int i = 0; i < 4; i++) begin
      s = ~s;
      @(posedge clk); #1;
    end
    s = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_out_q", 32'(out_q), 32'hA5);
    chk("pre_rst_sel_cnt", 32'(sel_cnt), CNT_EN ? 32'd3 : 32'd0);
    #2 rst = 1'b1;
    #1 chk("arst_out_q", 32'(out_q), 0);
    chk("arst_sel_cnt", 32'(sel_cnt), 0);
    chk("arst_out_b", 32'(out), 32'hA5);
    s = 1'b0;
    #1 chk("arst_out_a", 32'(out), 32'h3C);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_out_q", 32'(out_q), 32'h3C);
    chk("resume_sel_cnt", 32'(sel_cnt), 32'(exp_cnt()));

    // Saturating counter: toggle s every cycle from a fresh reset
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      @(posedge clk); #1;
      chk("cnt_seq", 32'(sel_cnt), CNT_EN ? 32'(cnt_seq[i]) : 32'd0);
      chk("cnt_model", 32'(sel_cnt), 32'(exp_cnt()));
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      s = 1'($urandom_range(0, 1));
      #1 chk("rnd_out", 32'(out), 32'(ref_out(a, b, s)));
      @(posedge clk); #1;
      chk("rnd_out_q", 32'(out_q), 32'(m_q));
      chk("rnd_sel_cnt", 32'(sel_cnt), 32'(exp_cnt()));
    end

    // Simultaneous change of a, b and s
    a = 8'h00; b = 8'h01; s = 1'b0;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h00; s = 1'b1;
    #1 chk("simul_out", 32'(out), 0);
    @(posedge clk); #1;
    chk("simul_out_q", 32'(out_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_2_1.md
MUX_2_1 -- requirements
Module: mux_2_1

Interface
REQ-001 Parameter WIDTH, default 1, data width of a, b, out and out_q.
REQ-002 Parameter CNT_W, default 8, width of sel_cnt.
REQ-003 clk  input  1  single clock; all sequential logic updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 a  input  WIDTH  data input selected when s=0.
REQ-006 b  input  WIDTH  data input selected when s=1.
REQ-007 s  input  1  select.
REQ-008 out  output  WIDTH  combinational mux result.
REQ-009 out_q  output  WIDTH  registered copy of out.
REQ-010 sel_cnt  output  CNT_W  saturating count of select transitions.
REQ-011 Positional port order SHALL be a, b, s, out, clk, rst, out_q, sel_cnt, so a four-port positional instance (a, b, s, out) maps to the combinational path.

Function
REQ-012 out SHALL equal a when s=0 and b when s=1, with zero clock latency.
REQ-013 out SHALL depend only on a, b and s, and SHALL be independent of clk and rst.
REQ-014 An X or Z value on s SHALL drive out to the bitwise merge: bits where a==b take that value, all other bits are X (simulation only).
REQ-015 out_q SHALL take the value of out on every rising clk edge, giving exactly one cycle of latency.
REQ-016 A register s_d SHALL capture s on every rising clk edge.
REQ-017 sel_cnt SHALL increment by 1 on each rising edge where s != s_d.
REQ-018 sel_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 The first edge after reset release SHALL compare s against the reset value of s_d (0).
REQ-020 A simultaneous change of a, b and s SHALL resolve out to the newly selected input within the same delta cycle, with no intermediate registered value.

Reset
REQ-021 While rst=1: out_q=0, s_d=0 and sel_cnt=0, applied immediately without waiting for clk.
REQ-022 Asserting rst mid-operation SHALL clear all registers asynchronously; out SHALL keep following its inputs.
REQ-023 After rst deasserts, the first rising clk edge SHALL resume normal updates.

Configuration
REQ-024 Macro MUX_2_1_SEL_CNT_EN controls the select-transition counter.
REQ-025 With MUX_2_1_SEL_CNT_EN defined: s_d and sel_cnt are implemented per REQ-016..REQ-019.
REQ-026 Without MUX_2_1_SEL_CNT_EN: sel_cnt is constant 0, and no s_d or counter flops exist.
REQ-027 out and out_q SHALL be unaffected by the macro.

Verification
REQ-028 Exhaustive combinational check: with WIDTH=1, drive {s,a,b}=0..7, holding each value 50 ns.
  - Required out sequence: 0,0,1,1,0,1,0,1.
REQ-029 Registered latency: WIDTH=8, rst=0, s=0, a=8'h3C, b=8'hA5.
  - Flip s to 1 just after an edge: out=8'hA5 immediately.
  - out_q=8'hA5 only after the next rising edge.
REQ-030 Async reset: with out_q=8'hA5 and sel_cnt=3, pulse rst high between edges.
  - Required: out_q=0 and sel_cnt=0 before the next edge.
  - Required: out still follows its inputs throughout.
REQ-031 Counter: with the macro defined and CNT_W=2, toggle s every cycle for 6 cycles.
  - Required sel_cnt sequence: 1,2,3,3,3,3 (saturation).
REQ-032 Macro off: repeat REQ-031; sel_cnt SHALL stay 0 throughout.
REQ-033 Simultaneous change: a=0, b=1, s=0, then set a=1, b=0, s=1 in the same timestep.
  - Required: out=0 with no glitch to 1 at a clock sample.
